// File: rtl/alu_share_arbiter.sv
// Two-port round-robin arbiter feeding one ALU through an issue register; result is registered per port.
// Latency: request accept to response valid = 2 cycles. Backpressure: a port is held off while its response slot is full and not draining.
// Optional perf counters are enabled by defining ALU_ARB_PERF_EN.
module alu_share_arbiter #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 4
) (
   input  logic                       i_clock,
   input  logic                       i_rst_n,
   input  logic [1:0]                 i_req_valid,
   output logic [1:0]                 o_req_ready,
   input  logic [1:0][XLEN-1:0]       i_req_a,
   input  logic [1:0][XLEN-1:0]       i_req_b,
   input  logic [1:0][3:0]            i_req_t,
   input  logic [1:0][2:0]            i_req_ctl,
   input  logic [1:0][TAG_W-1:0]      i_req_tag,
   output logic [XLEN-1:0]            o_alu_a,
   output logic [XLEN-1:0]            o_alu_b,
   output logic [3:0]                 o_alu_t,
   output logic                       o_alu_sub,
   output logic                       o_alu_sign,
   output logic                       o_alu_sra,
   input  logic [XLEN-1:0]            i_alu_res,
   output logic [1:0]                 o_rsp_valid,
   input  logic [1:0]                 i_rsp_ready,
   output logic [1:0][XLEN-1:0]       o_rsp_data,
   output logic [1:0][TAG_W-1:0]      o_rsp_tag
`ifdef ALU_ARB_PERF_EN
   ,
   output logic [31:0]                o_perf_grant0,
   output logic [31:0]                o_perf_grant1,
   output logic [31:0]                o_perf_conflict
`endif
);

   typedef enum logic {S_IDLE, S_ISSUE} state_e;

   state_e                  state_q, state_d;
   logic                    own_q, own_d;
   logic                    ptr_q, ptr_d;
   logic [TAG_W-1:0]        iss_tag_q, iss_tag_d;
   logic [XLEN-1:0]         alu_a_q, alu_a_d, alu_b_q, alu_b_d;
   logic [3:0]              alu_t_q, alu_t_d;
   logic [2:0]              alu_ctl_q, alu_ctl_d;
   logic [1:0]              rsp_vld_q, rsp_vld_d;
   logic [1:0][XLEN-1:0]    rsp_dat_q, rsp_dat_d;
   logic [1:0][TAG_W-1:0]   rsp_tag_q, rsp_tag_d;

   logic [1:0]              busy;
   logic [1:0]              elig;
   logic [1:0]              grant;
   logic                    gsel;

   // busy doubles as the landing mask: the issue owner's slot is written at the end of this cycle
   assign busy = {(state_q == S_ISSUE) && own_q, (state_q == S_ISSUE) && !own_q};
   assign elig = i_req_valid & (~rsp_vld_q | i_rsp_ready) & ~busy;

   always_comb begin
      grant     = elig;
      state_d   = S_IDLE;
      own_d     = own_q;
      ptr_d     = ptr_q;
      iss_tag_d = iss_tag_q;
      alu_a_d   = alu_a_q;
      alu_b_d   = alu_b_q;
      alu_t_d   = alu_t_q;
      alu_ctl_d = alu_ctl_q;
      rsp_vld_d = rsp_vld_q;
      rsp_dat_d = rsp_dat_q;
      rsp_tag_d = rsp_tag_q;

      if (elig == 2'b11) begin
         grant = ptr_q ? 2'b10 : 2'b01;
      end
      gsel = grant[1];

      if (grant != 2'b00) begin
         state_d   = S_ISSUE;
         own_d     = gsel;
         ptr_d     = ~ptr_q;
         iss_tag_d = i_req_tag[gsel];
         alu_a_d   = i_req_a[gsel];
         alu_b_d   = i_req_b[gsel];
         alu_t_d   = i_req_t[gsel];
         alu_ctl_d = i_req_ctl[gsel];
      end

      // a landing result takes priority over a drain so back-to-back replace loses nothing
      for (int p = 0; p < 2; p++) begin
         if (busy[p]) begin
            rsp_vld_d[p] = 1'b1;
            rsp_dat_d[p] = i_alu_res;
            rsp_tag_d[p] = iss_tag_q;
         end else if (i_rsp_ready[p]) begin
            rsp_vld_d[p] = 1'b0;
         end
      end
   end

   always_ff @(posedge i_clock or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= S_IDLE;
         own_q     <= 1'b0;
         ptr_q     <= 1'b0;
         iss_tag_q <= '0;
         alu_a_q   <= '0;
         alu_b_q   <= '0;
         alu_t_q   <= '0;
         alu_ctl_q <= '0;
         rsp_vld_q <= '0;
         rsp_dat_q <= '0;
         rsp_tag_q <= '0;
      end else begin
         state_q   <= state_d;
         own_q     <= own_d;
         ptr_q     <= ptr_d;
         iss_tag_q <= iss_tag_d;
         alu_a_q   <= alu_a_d;
         alu_b_q   <= alu_b_d;
         alu_t_q   <= alu_t_d;
         alu_ctl_q <= alu_ctl_d;
         rsp_vld_q <= rsp_vld_d;
         rsp_dat_q <= rsp_dat_d;
         rsp_tag_q <= rsp_tag_d;
      end
   end

   assign o_req_ready = grant;
   assign o_alu_a     = alu_a_q;
   assign o_alu_b     = alu_b_q;
   assign o_alu_t     = alu_t_q;
   assign o_alu_sub   = alu_ctl_q[2];
   assign o_alu_sign  = alu_ctl_q[1];
   assign o_alu_sra   = alu_ctl_q[0];
   assign o_rsp_valid = rsp_vld_q;
   assign o_rsp_data  = rsp_dat_q;
   assign o_rsp_tag   = rsp_tag_q;

`ifdef ALU_ARB_PERF_EN
   logic [31:0] perf_g0_q, perf_g1_q, perf_cf_q;
   logic [31:0] perf_g0_d, perf_g1_d, perf_cf_d;

   always_comb begin
      perf_g0_d = perf_g0_q;
      perf_g1_d = perf_g1_q;
      perf_cf_d = perf_cf_q;
      if (grant[0] && (perf_g0_q != 32'hFFFF_FFFF)) perf_g0_d = perf_g0_q + 32'd1;
      if (grant[1] && (perf_g1_q != 32'hFFFF_FFFF)) perf_g1_d = perf_g1_q + 32'd1;
      if ((&i_req_valid) && (perf_cf_q != 32'hFFFF_FFFF)) perf_cf_d = perf_cf_q + 32'd1;
   end

   always_ff @(posedge i_clock or negedge i_rst_n) begin
      if (!i_rst_n) begin
         perf_g0_q <= '0;
         perf_g1_q <= '0;
         perf_cf_q <= '0;
      end else begin
         perf_g0_q <= perf_g0_d;
         perf_g1_q <= perf_g1_d;
         perf_cf_q <= perf_cf_d;
      end
   end

   assign o_perf_grant0   = perf_g0_q;
   assign o_perf_grant1   = perf_g1_q;
   assign o_perf_conflict = perf_cf_q;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_alu_share_arbiter;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [1:0]        req_v;
   logic [1:0]        req_rdy;
   logic [1:0][31:0]  req_a, req_b;
   logic [1:0][3:0]   req_t;
   logic [1:0][2:0]   req_ctl;
   logic [1:0][3:0]   req_tag;
   logic [31:0]       alu_a, alu_b;
   logic [3:0]        alu_t;
   logic              alu_sub, alu_sign, alu_sra;
   logic [31:0]       alu_res;
   logic [1:0]        rsp_v;
   logic [1:0]        rsp_rdy;
   logic [1:0][31:0]  rsp_dat;
   logic [1:0][3:0]   rsp_tag;
`ifdef ALU_ARB_PERF_EN
   logic [31:0]       perf_g0, perf_g1, perf_cf;
`endif

   int errs   = 0;
   int checks = 0;

   always #5 clk = ~clk;

   // stand-in ALU: add with carry-in from sub
   assign alu_res = alu_a + alu_b + {31'd0, alu_sub};

   alu_share_arbiter #(.XLEN(32), .TAG_W(4)) dut (
      .i_clock(clk), .i_rst_n(rst_n),
      .i_req_valid(req_v), .o_req_ready(req_rdy),
      .i_req_a(req_a), .i_req_b(req_b), .i_req_t(req_t),
      .i_req_ctl(req_ctl), .i_req_tag(req_tag),
      .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_t(alu_t),
      .o_alu_sub(alu_sub), .o_alu_sign(alu_sign), .o_alu_sra(alu_sra),
      .i_alu_res(alu_res),
      .o_rsp_valid(rsp_v), .i_rsp_ready(rsp_rdy),
      .o_rsp_data(rsp_dat), .o_rsp_tag(rsp_tag)
`ifdef ALU_ARB_PERF_EN
      , .o_perf_grant0(perf_g0), .o_perf_grant1(perf_g1), .o_perf_conflict(perf_cf)
`endif
   );

   // transaction-level model: per-port grant cycle, pending result, response slot
   int          m_cyc;
   int          m_gcyc[2];
   bit          m_full[2];
   logic [31:0] m_sdat[2], m_pdat[2];
   logic [3:0]  m_stag[2], m_ptag[2];
   bit          m_ptr;
   logic [31:0] m_ia, m_ib;
   logic [3:0]  m_it;
   logic [2:0]  m_ictl;

   task automatic model_reset();
      m_cyc = 0;
      m_ptr = 1'b0;
      for (int p = 0; p < 2; p++) begin
         m_gcyc[p] = -10;
         m_full[p] = 1'b0;
      end
   endtask

   task automatic model_eval(output logic [1:0] g, output bit iss_v);
      bit in_issue[2];
      bit el[2];
      iss_v = 1'b0;
      for (int p = 0; p < 2; p++) begin
         in_issue[p] = (m_gcyc[p] == m_cyc - 1);
         if (in_issue[p]) iss_v = 1'b1;
         el[p] = req_v[p] && (!m_full[p] || rsp_rdy[p]) && !in_issue[p];
      end
      g = 2'b00;
      if (el[0] && el[1]) g[m_ptr] = 1'b1;
      else if (el[0])     g[0] = 1'b1;
      else if (el[1])     g[1] = 1'b1;
   endtask

   task automatic model_commit(input logic [1:0] g);
      for (int p = 0; p < 2; p++) begin
         if (m_full[p] && rsp_rdy[p]) m_full[p] = 1'b0;
         if (m_gcyc[p] == m_cyc - 1) begin
            m_full[p] = 1'b1;
            m_sdat[p] = m_pdat[p];
            m_stag[p] = m_ptag[p];
         end
      end
      for (int p = 0; p < 2; p++) begin
         if (g[p]) begin
            m_pdat[p] = req_a[p] + req_b[p] + {31'd0, req_ctl[p][2]};
            m_ptag[p] = req_tag[p];
            m_gcyc[p] = m_cyc;
            m_ia = req_a[p]; m_ib = req_b[p]; m_it = req_t[p]; m_ictl = req_ctl[p];
            m_ptr = ~m_ptr;
         end
      end
      m_cyc++;
   endtask

   task automatic clear_inputs();
      req_v = '0; rsp_rdy = '0;
      req_a = '0; req_b = '0; req_t = '0; req_ctl = '0; req_tag = '0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clear_inputs();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      clear_inputs();
      @(negedge clk); #1;
      checks++;
      if ({rsp_v, req_rdy} !== 4'b0) begin
         errs++; $display("FAIL reset_valid: got rsp_v=%b ready=%b want 0", rsp_v, req_rdy);
      end
      checks++;
      if ({alu_a, alu_b, alu_t, alu_sub, alu_sign, alu_sra} !== '0) begin
         errs++; $display("FAIL reset_alu: got a=%h b=%h t=%h want 0", alu_a, alu_b, alu_t);
      end
      checks++;
      if ({rsp_dat, rsp_tag} !== '0) begin
         errs++; $display("FAIL reset_rsp: got data=%h tag=%h want 0", rsp_dat, rsp_tag);
      end
      do_reset();
   endtask

   task automatic test_single_op();
      do_reset();
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         req_v = (c == 0) ? 2'b01 : 2'b00;
         req_a[0] = 32'd5; req_b[0] = 32'd3; req_t[0] = 4'd0; req_ctl[0] = 3'd0; req_tag[0] = 4'd1;
         rsp_rdy = 2'b11;
         #1;
         if (c == 0) begin
            checks++;
            if (req_rdy !== 2'b01) begin
               errs++; $display("FAIL single_ready: got %b want 01", req_rdy);
            end
         end else if (c == 1) begin
            checks++;
            if (rsp_v !== 2'b00 || alu_a !== 32'd5 || alu_b !== 32'd3) begin
               errs++; $display("FAIL single_issue: got rsp_v=%b a=%0d b=%0d want 00/5/3", rsp_v, alu_a, alu_b);
            end
         end else if (c == 2) begin
            checks++;
            if (rsp_v !== 2'b01 || rsp_dat[0] !== 32'd8 || rsp_tag[0] !== 4'd1) begin
               errs++; $display("FAIL single_rsp: got v=%b data=%0d tag=%0d want 01/8/1", rsp_v, rsp_dat[0], rsp_tag[0]);
            end
         end else begin
            checks++;
            if (rsp_v !== 2'b00) begin
               errs++; $display("FAIL single_drain: got rsp_v=%b want 00", rsp_v);
            end
         end
      end
   endtask

   task automatic test_alternate();
      logic [1:0]  exp_g;
      logic [31:0] exp_d;
      do_reset();
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         req_v = 2'b11; rsp_rdy = 2'b11;
         for (int p = 0; p < 2; p++) begin
            req_a[p] = 32'(c * 16 + p); req_b[p] = 32'd7; req_ctl[p] = 3'd0; req_tag[p] = 4'(c);
         end
         #1;
         exp_g = (c % 2 == 0) ? 2'b01 : 2'b10;
         checks++;
         if (req_rdy !== exp_g) begin
            errs++; $display("FAIL alt_grant c=%0d: got %b want %b", c, req_rdy, exp_g);
         end
         if (c >= 2) begin
            exp_d = 32'((c - 2) * 16 + (c % 2) + 7);
            checks++;
            if (rsp_v !== exp_g || rsp_dat[c % 2] !== exp_d || rsp_tag[c % 2] !== 4'(c - 2)) begin
               errs++; $display("FAIL alt_rsp c=%0d: got v=%b data=%0d tag=%0d want %b/%0d/%0d",
                                c, rsp_v, rsp_dat[c % 2], rsp_tag[c % 2], exp_g, exp_d, c - 2);
            end
         end
      end
   endtask

   task automatic test_hold_port1();
      do_reset();
      for (int c = 0; c < 9; c++) begin
         @(negedge clk);
         req_v   = (c == 0) ? 2'b10 : ((c == 8) ? 2'b10 : 2'b11);
         rsp_rdy = (c == 8) ? 2'b11 : 2'b01;
         req_a[1] = 32'h100; req_b[1] = 32'h23; req_ctl[1] = 3'd0; req_tag[1] = 4'd9;
         req_a[0] = 32'(c); req_b[0] = 32'd0; req_ctl[0] = 3'd0; req_tag[0] = 4'(c);
         #1;
         if (c >= 2 && c <= 7) begin
            checks++;
            if (req_rdy !== {1'b0, c[0]}) begin
               errs++; $display("FAIL hold_grant c=%0d: got %b want %b", c, req_rdy, {1'b0, c[0]});
            end
            checks++;
            if (rsp_v[1] !== 1'b1 || rsp_dat[1] !== 32'h123 || rsp_tag[1] !== 4'd9) begin
               errs++; $display("FAIL hold_slot c=%0d: got v=%b data=%h tag=%0d want 1/123/9", c, rsp_v[1], rsp_dat[1], rsp_tag[1]);
            end
         end else if (c == 8) begin
            checks++;
            if (req_rdy !== 2'b10) begin
               errs++; $display("FAIL hold_release: got %b want 10", req_rdy);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] q[$];
      logic [3:0] nt;
      int         pops;
      do_reset();
      nt = 4'd0; pops = 0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         req_v = 2'b01;
         rsp_rdy = ($urandom_range(0, 3) != 0) ? 2'b01 : 2'b00;
         req_tag[0] = nt; req_a[0] = {28'd0, nt} * 32'd3; req_b[0] = 32'd0; req_ctl[0] = 3'd0;
         #1;
         if (rsp_v[0] && rsp_rdy[0]) begin
            checks++;
            if (q.size() == 0 || rsp_tag[0] !== q[0] || rsp_dat[0] !== {28'd0, q[0]} * 32'd3) begin
               errs++; $display("FAIL b2b_order: got tag=%0d data=%0d want tag=%0d", rsp_tag[0], rsp_dat[0],
                                (q.size() != 0) ? q[0] : 4'd0);
            end
            if (q.size() != 0) void'(q.pop_front());
            pops++;
         end
         if (req_rdy[0]) begin
            q.push_back(nt);
            nt = nt + 4'd1;
         end
      end
      checks++;
      if (q.size() > 2 || pops < 10) begin
         errs++; $display("FAIL b2b_count: got outstanding=%0d consumed=%0d want <=2 and >=10", q.size(), pops);
      end
   endtask

   task automatic test_random();
      logic [1:0] g;
      bit         iss_v;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         for (int p = 0; p < 2; p++) begin
            req_v[p]   = ($urandom_range(0, 3) != 0);
            rsp_rdy[p] = ($urandom_range(0, 4) >= 2);
            req_a[p]   = $urandom;
            req_b[p]   = $urandom;
            req_t[p]   = 4'($urandom);
            req_ctl[p] = 3'($urandom);
            req_tag[p] = 4'($urandom);
         end
         #1;
         model_eval(g, iss_v);
         checks++;
         if (req_rdy !== g) begin
            errs++; $display("FAIL rnd_grant c=%0d: got %b want %b", c, req_rdy, g);
         end
         checks++;
         if (rsp_v !== {m_full[1], m_full[0]}) begin
            errs++; $display("FAIL rnd_rsp_v c=%0d: got %b want %b%b", c, rsp_v, m_full[1], m_full[0]);
         end
         for (int p = 0; p < 2; p++) begin
            if (m_full[p]) begin
               checks++;
               if (rsp_dat[p] !== m_sdat[p] || rsp_tag[p] !== m_stag[p]) begin
                  errs++; $display("FAIL rnd_rsp_dat c=%0d p=%0d: got %h/%0d want %h/%0d",
                                   c, p, rsp_dat[p], rsp_tag[p], m_sdat[p], m_stag[p]);
               end
            end
         end
         if (iss_v) begin
            checks++;
            if (alu_a !== m_ia || alu_b !== m_ib || alu_t !== m_it || {alu_sub, alu_sign, alu_sra} !== m_ictl) begin
               errs++; $display("FAIL rnd_alu c=%0d: got %h/%h/%h/%b want %h/%h/%h/%b", c, alu_a, alu_b, alu_t,
                                {alu_sub, alu_sign, alu_sra}, m_ia, m_ib, m_it, m_ictl);
            end
         end
         model_commit(g);
      end
   endtask

   task automatic test_reset_midop();
      do_reset();
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         req_v = (c == 0) ? 2'b01 : ((c == 1) ? 2'b10 : 2'b00);
         rsp_rdy = 2'b00;
         req_a = {32'd40, 32'd20}; req_b = {32'd2, 32'd1}; req_tag = {4'd6, 4'd5};
      end
      #1;
      checks++;
      if (rsp_v !== 2'b01) begin
         errs++; $display("FAIL midop_pre: got rsp_v=%b want 01", rsp_v);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({rsp_v, req_rdy, rsp_dat, rsp_tag, alu_a, alu_b} !== '0) begin
         errs++; $display("FAIL midop_zero: got rsp_v=%b data=%h a=%h want 0", rsp_v, rsp_dat, alu_a);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         req_v = (c == 3) ? 2'b01 : 2'b00;
         rsp_rdy = 2'b00;
         #1;
         checks++;
         if (rsp_v !== ((c == 5) ? 2'b01 : 2'b00)) begin
            errs++; $display("FAIL midop_after c=%0d: got rsp_v=%b want %b", c, rsp_v, (c == 5) ? 2'b01 : 2'b00);
         end
      end
   endtask

`ifdef ALU_ARB_PERF_EN
   task automatic test_perf();
      do_reset();
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         req_v = (c < 10) ? 2'b11 : 2'b00;
         rsp_rdy = 2'b11;
      end
      #1;
      checks++;
      if (perf_cf !== 32'd10 || perf_g0 !== 32'd5 || perf_g1 !== 32'd5) begin
         errs++; $display("FAIL perf_counts: got cf=%0d g0=%0d g1=%0d want 10/5/5", perf_cf, perf_g0, perf_g1);
      end
      force dut.perf_g0_q = 32'hFFFF_FFFF;
      @(negedge clk);
      release dut.perf_g0_q;
      req_v = 2'b01;
      @(negedge clk);
      req_v = 2'b00;
      #1;
      checks++;
      if (perf_g0 !== 32'hFFFF_FFFF) begin
         errs++; $display("FAIL perf_sat: got %h want ffffffff", perf_g0);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single_op();
      test_alternate();
      test_hold_port1();
      test_back_to_back();
      test_random();
      test_reset_midop();
`ifdef ALU_ARB_PERF_EN
      test_perf();
`endif
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
